// File: rtl/regfile_pkg.sv
// Shared constants for the regfile_sb register file: default geometry and
// the clear-engine state encoding.
package regfile_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_NRD    = 2;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_CLEAR = 1'b1;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for regfile_sb: one pending bit per register, set by an
// accepted issue, cleared by writeback, wiped by the clear engine.
// Optional feature: REGFILE_ZERO_REG_EN keeps register 0 permanently not-busy
// and always accepts issues to it while idle.
import regfile_pkg::*;

module regfile_scoreboard #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = DEF_NRD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  idle,
  input  logic                  issue_valid,
  input  logic [ADDR_W-1:0]     issue_addr,
  input  logic                  wr_fire,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic                  clr_all,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic                  issue_ready,
  output logic [NRD-1:0]        rd_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic             issue_fire;

  // A reservation is possible when the target is free or is being written back right now
  always_comb begin
    issue_ready = idle & (~busy[issue_addr] | (wr_fire & (wr_addr == issue_addr)));
`ifdef REGFILE_ZERO_REG_EN
    if (issue_addr == '0) begin
      issue_ready = idle;
    end
`endif
    issue_fire = issue_valid & issue_ready;
  end

  // Per-port hazard lookup; a same-cycle writeback resolves the hazard
  always_comb begin
    logic [ADDR_W-1:0] a;
    a       = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      a          = rd_addr[k*ADDR_W +: ADDR_W];
      rd_busy[k] = busy[a] & ~(wr_fire & (a == wr_addr));
    end
  end

  // Next busy vector: writeback clears, the new producer's issue wins, clear-all overrides both
  always_comb begin
    busy_next = busy;
    if (wr_fire) begin
      busy_next[wr_addr] = 1'b0;
    end
    if (issue_fire) begin
      busy_next[issue_addr] = 1'b1;
    end
    if (clr_all) begin
      busy_next = '0;
    end
`ifdef REGFILE_ZERO_REG_EN
    busy_next[0] = 1'b0;
`endif
  end

  // Busy bits register
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with write-first bypass, a busy
// scoreboard for issue/writeback hazards and a one-register-per-cycle clear
// engine. Synchronous active-low reset.
// Optional feature: REGFILE_ZERO_REG_EN hardwires register 0 to zero.
import regfile_pkg::*;

module regfile_sb #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = DEF_NRD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [ADDR_W-1:0]     issue_addr,
  output logic                  issue_ready,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  clr_start,
  output logic                  clr_active,
  output logic                  clr_done
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] regs [DEPTH];
  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic              idle;
  logic              wr_fire;
  logic              wr_store;
  logic              clr_all;

  assign idle       = (state == ST_IDLE);
  assign clr_active = (state == ST_CLEAR);
  assign wr_fire    = wr_en & idle;
  assign clr_all    = idle & clr_start;

`ifdef REGFILE_ZERO_REG_EN
  assign wr_store = wr_fire & (wr_addr != '0);
`else
  assign wr_store = wr_fire;
`endif

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NRD    (NRD)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .idle        (idle),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .wr_fire     (wr_fire),
    .wr_addr     (wr_addr),
    .clr_all     (clr_all),
    .rd_addr     (rd_addr),
    .issue_ready (issue_ready),
    .rd_busy     (rd_busy)
  );

  // Clear engine: sweep index 0..DEPTH-1, then pulse clr_done for one cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clr_start) begin
            state <= ST_CLEAR;
            idx   <= '0;
          end
        end
        ST_CLEAR: begin
          if (idx == LAST_IDX) begin
            state    <= ST_IDLE;
            idx      <= '0;
            clr_done <= 1'b1;
          end else begin
            idx <= idx + ADDR_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  // Register array: the clear sweep has priority, writebacks only land while idle
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (clr_active) begin
      regs[idx] <= '0;
    end else if (wr_store) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read ports: write-first bypass while idle, otherwise straight from the array
  always_comb begin
    logic [ADDR_W-1:0] a;
    a       = '0;
    rd_data = '0;
    for (int k = 0; k < NRD; k++) begin
      a = rd_addr[k*ADDR_W +: ADDR_W];
      if (wr_fire && (a == wr_addr)) begin
        rd_data[k*DATA_W +: DATA_W] = wr_data;
      end else begin
        rd_data[k*DATA_W +: DATA_W] = regs[a];
      end
`ifdef REGFILE_ZERO_REG_EN
      if (a == '0) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: a behavioural model predicts every output
// each cycle, and directed vectors carry hand-computed literal expectations.
// Honours REGFILE_ZERO_REG_EN the same way as the design.
module tb_regfile_sb;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NRD    = 2;
  localparam int DEPTH  = 8;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic                  clk;
  logic                  rst;
  logic                  issue_valid;
  logic [ADDR_W-1:0]     issue_addr;
  logic                  issue_ready;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  clr_start;
  logic                  clr_active;
  logic                  clr_done;

  int checks = 0;
  int errors = 0;

  regfile_sb dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .issue_ready (issue_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .clr_start   (clr_start),
    .clr_active  (clr_active),
    .clr_done    (clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: register contents, pending flags, cycles of clearing left
  logic [DATA_W-1:0] mreg [DEPTH];
  bit                mbusy [DEPTH];
  int                clear_left = 0;
  bit                mdone = 1'b0;
  bit                model_valid = 1'b0;

  function automatic logic [DATA_W-1:0] exp_rd_data(input int a);
    if (ZERO && a == 0) return '0;
    if (clear_left == 0 && wr_en && int'(wr_addr) == a) return wr_data;
    return mreg[a];
  endfunction

  function automatic logic exp_rd_busy(input int a);
    return mbusy[a] && !(clear_left == 0 && wr_en && int'(wr_addr) == a);
  endfunction

  function automatic logic exp_issue_ready();
    if (clear_left != 0) return 1'b0;
    if (ZERO && issue_addr == 0) return 1'b1;
    return !mbusy[issue_addr] || (wr_en && wr_addr == issue_addr);
  endfunction

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Advance the model on each rising edge using the inputs that the DUT samples
  always @(posedge clk) begin
    bit ready_now;
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mreg[i]  = '0;
        mbusy[i] = 1'b0;
      end
      clear_left  = 0;
      mdone       = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (clear_left > 0) begin
        mreg[DEPTH - clear_left] = '0;
        clear_left = clear_left - 1;
        mdone = (clear_left == 0);
      end else begin
        ready_now = exp_issue_ready();
        mdone = 1'b0;
        if (wr_en) begin
          if (!(ZERO && wr_addr == 0)) mreg[wr_addr] = wr_data;
          mbusy[wr_addr] = 1'b0;
        end
        if (issue_valid && ready_now) mbusy[issue_addr] = 1'b1;
        if (clr_start) begin
          for (int i = 0; i < DEPTH; i++) mbusy[i] = 1'b0;
          clear_left = DEPTH;
        end
        if (ZERO) mbusy[0] = 1'b0;
      end
    end
  end

  // Compare every output against the model mid-cycle
  always @(negedge clk) begin
    if (model_valid) begin
      for (int k = 0; k < NRD; k++) begin
        checkOutput($sformatf("model rd_data%0d", k), rd_data[k*DATA_W +: DATA_W],
                    exp_rd_data(int'(rd_addr[k*ADDR_W +: ADDR_W])));
        checkOutput($sformatf("model rd_busy%0d", k), {15'd0, rd_busy[k]},
                    {15'd0, exp_rd_busy(int'(rd_addr[k*ADDR_W +: ADDR_W]))});
      end
      checkOutput("model issue_ready", {15'd0, issue_ready}, {15'd0, exp_issue_ready()});
      checkOutput("model clr_active", {15'd0, clr_active}, {15'd0, clear_left != 0});
      checkOutput("model clr_done", {15'd0, clr_done}, {15'd0, mdone});
    end
  end

  // One cycle of stimulus: drive after the edge, return once outputs have settled
  task automatic applyStimulus(input logic iv, input logic [ADDR_W-1:0] ia,
                               input logic we, input logic [ADDR_W-1:0] wa,
                               input logic [DATA_W-1:0] wd,
                               input logic [ADDR_W-1:0] r0, input logic [ADDR_W-1:0] r1,
                               input logic cs);
    @(posedge clk);
    #1;
    issue_valid = iv;
    issue_addr  = ia;
    wr_en       = we;
    wr_addr     = wa;
    wr_data     = wd;
    rd_addr     = {r1, r0};
    clr_start   = cs;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    issue_valid = 1'b0;
    issue_addr = '0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    clr_start = 1'b0;

    repeat (2) applyStimulus(0, 0, 0, 0, 16'h0, 0, 0, 0);
    rst = 1'b1;

    // Post-reset state
    applyStimulus(0, 0, 0, 0, 16'h0, 0, 0, 0);
    checkOutput("reset rd_data0", rd_data[15:0], 16'h0000);
    checkOutput("reset rd_data1", rd_data[31:16], 16'h0000);
    checkOutput("reset rd_busy", {14'd0, rd_busy}, 16'h0000);
    checkOutput("reset issue_ready", {15'd0, issue_ready}, 16'h0001);
    checkOutput("reset clr_active", {15'd0, clr_active}, 16'h0000);

    // Write bypass then array read
    applyStimulus(0, 0, 1, 3, 16'hBEEF, 3, 0, 0);
    checkOutput("bypass reg3", rd_data[15:0], 16'hBEEF);
    applyStimulus(0, 0, 0, 0, 16'h0, 3, 0, 0);
    checkOutput("array reg3", rd_data[15:0], 16'hBEEF);

    // Issue reservation and writeback release
    applyStimulus(1, 5, 0, 0, 16'h0, 3, 5, 0);
    checkOutput("issue5 ready", {15'd0, issue_ready}, 16'h0001);
    checkOutput("issue5 busy same cycle", {15'd0, rd_busy[1]}, 16'h0000);
    applyStimulus(1, 5, 0, 0, 16'h0, 3, 5, 0);
    checkOutput("reissue5 ready", {15'd0, issue_ready}, 16'h0000);
    checkOutput("issue5 busy", {15'd0, rd_busy[1]}, 16'h0001);
    applyStimulus(0, 0, 1, 5, 16'h0042, 3, 5, 0);
    checkOutput("wb5 busy", {15'd0, rd_busy[1]}, 16'h0000);
    checkOutput("wb5 data", rd_data[31:16], 16'h0042);
    applyStimulus(0, 0, 0, 0, 16'h0, 3, 5, 0);
    checkOutput("after wb5 busy", {15'd0, rd_busy[1]}, 16'h0000);
    checkOutput("after wb5 data", rd_data[31:16], 16'h0042);

    // Same-cycle issue and write to a busy register
    applyStimulus(1, 2, 0, 0, 16'h0, 2, 2, 0);
    applyStimulus(1, 2, 1, 2, 16'h1234, 2, 2, 0);
    checkOutput("issue+wb2 ready", {15'd0, issue_ready}, 16'h0001);
    checkOutput("issue+wb2 bypass", rd_data[15:0], 16'h1234);
    applyStimulus(0, 0, 0, 0, 16'h0, 2, 2, 0);
    checkOutput("reg2 data", rd_data[15:0], 16'h1234);
    checkOutput("reg2 busy", {15'd0, rd_busy[0]}, 16'h0001);

    // Fill, then a full clear with writes and issues attempted throughout
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(0, 0, 1, ADDR_W'(i), 16'h1001 + 16'(i), ADDR_W'(i), 0, 0);
    applyStimulus(0, 0, 0, 0, 16'h0, 0, 1, 1);
    checkOutput("clr_start cycle active", {15'd0, clr_active}, 16'h0000);
    for (int c = 1; c <= DEPTH; c++) begin
      applyStimulus(1, 4, 1, 7, 16'hFFFF, ADDR_W'(c - 1), 7, 0);
      checkOutput("clear active", {15'd0, clr_active}, 16'h0001);
      checkOutput("clear issue_ready", {15'd0, issue_ready}, 16'h0000);
      checkOutput("clear reg7 no bypass", rd_data[31:16], 16'h1008);
      checkOutput("clear no done", {15'd0, clr_done}, 16'h0000);
    end
    applyStimulus(0, 0, 0, 0, 16'h0, 7, 4, 0);
    checkOutput("clr_done pulse", {15'd0, clr_done}, 16'h0001);
    checkOutput("clr_done inactive", {15'd0, clr_active}, 16'h0000);
    checkOutput("reg7 cleared", rd_data[15:0], 16'h0000);
    applyStimulus(0, 0, 0, 0, 16'h0, 7, 4, 0);
    checkOutput("clr_done single", {15'd0, clr_done}, 16'h0000);
    for (int i = 0; i < DEPTH / 2; i++)
      applyStimulus(0, 0, 0, 0, 16'h0, ADDR_W'(2 * i), ADDR_W'(2 * i + 1), 0);

    // Second clear aborted by reset in its fourth cycle
    applyStimulus(0, 0, 1, 6, 16'h6666, 6, 0, 0);
    applyStimulus(0, 0, 0, 0, 16'h0, 6, 0, 1);
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(0, 0, 0, 0, 16'h0, 6, 7, 0);
      checkOutput("clear2 active", {15'd0, clr_active}, 16'h0001);
    end
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 16'h0, 6, 7, 0);
    checkOutput("abort active", {15'd0, clr_active}, 16'h0000);
    checkOutput("abort no done", {15'd0, clr_done}, 16'h0000);
    checkOutput("abort reg6", rd_data[15:0], 16'h0000);
    rst = 1'b1;
    repeat (DEPTH) begin
      applyStimulus(0, 0, 0, 0, 16'h0, 6, 7, 0);
      checkOutput("abort no late done", {15'd0, clr_done}, 16'h0000);
    end

    // Register 0 behaviour
    applyStimulus(0, 0, 1, 0, 16'hFFFF, 0, 0, 0);
    checkOutput("reg0 bypass", rd_data[15:0], ZERO ? 16'h0000 : 16'hFFFF);
    applyStimulus(1, 0, 0, 0, 16'h0, 0, 0, 0);
    checkOutput("reg0 array", rd_data[15:0], ZERO ? 16'h0000 : 16'hFFFF);
    checkOutput("reg0 issue_ready", {15'd0, issue_ready}, 16'h0001);
    applyStimulus(0, 0, 0, 0, 16'h0, 0, 0, 0);
    checkOutput("reg0 busy", {15'd0, rd_busy[0]}, ZERO ? 16'h0000 : 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
